mem_access_unit: RTL and testbench

Parametrised RV32 memory-access stage sitting between the EX/MEM and MEM/WB pipeline registers. Issues load/store requests to data memory over a req/ack handshake with variable latency, aligns store data to byte lanes, and extracts and sign- or zero-extends load data by byte offset. Detects misaligned, illegal and failed accesses and raises a precise exception instead of touching memory. Stalls upstream while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : RV32 memory-access stage between EX/MEM and MEM/WB. Issues
//            load/store requests over a req/ack handshake with variable
//            latency, places store data on byte lanes, extracts and
//            sign/zero-extends load data, and turns illegal, misaligned,
//            erroring or timed-out accesses into precise exceptions.
//
// Ports    : clk, rst_n                       clock, async active-low reset
//            valid_in, alu_result_in,         EX/MEM instruction fields
//            store_data_in, mem_read_en_in,
//            mem_write_en_in, funct3_in,
//            rd_in, reg_write_in
//            stall_out                        hold upstream while BUSY
//            dmem_req/we/addr/wdata/be        data-memory request
//            dmem_ack/err/rdata               data-memory response
//            wb_valid/data/rd/reg_write       retire to MEM/WB
//            exc_valid/cause/addr             precise exception report
//
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [2:0]        funct3_in,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic              dmem_err,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr
);

  // A zero MAX_WAIT disables the timeout; keep a 1-bit counter in that case
  // so the declaration stays legal.
  localparam int              CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT  = 4'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  // Transaction context captured on accept, used when the access retires.
  logic              lsu_load;
  logic [2:0]        lsu_f3;
  logic [1:0]        lsu_off;
  logic [4:0]        lsu_rd;
  logic              lsu_rw;
  logic [ADDR_W-1:0] lsu_addr;

  // Decode of the incoming instruction.
  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  req_cause;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  // Load extraction of the returning data.
  logic [31:0] rdata_shift;
  logic [31:0] load_data;
  logic        timeout;

  always_comb begin
    is_mem     = mem_read_en_in | mem_write_en_in;
    illegal    = (mem_read_en_in & mem_write_en_in)
               | (mem_read_en_in & ((funct3_in == 3'b011) | (funct3_in == 3'b110)
                                    | (funct3_in == 3'b111)))
               | (mem_write_en_in & (funct3_in >= 3'b011));
    misaligned = ((funct3_in[1:0] == 2'b01) & alu_result_in[0])
               | ((funct3_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00));
    // Illegal encodings take precedence over alignment.
    req_cause  = illegal ? CAUSE_ILLEGAL
                         : (mem_read_en_in ? CAUSE_LD_MISAL : CAUSE_ST_MISAL);

    lane_wdata = store_data_in;
    lane_be    = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        lane_wdata = {4{store_data_in[7:0]}};
        lane_be    = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data_in[15:0]}};
        lane_be    = 4'b0011 << alu_result_in[1:0];
      end
      default: begin
        lane_wdata = store_data_in;
        lane_be    = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0; a legal word access always
  // has zero offset, so the shifted value equals the raw read data.
  always_comb begin
    rdata_shift = dmem_rdata >> {lsu_off, 3'b000};
    load_data   = rdata_shift;
    case (lsu_f3)
      3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_data = {24'd0, rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b101:  load_data = {16'd0, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

  // The last BUSY cycle without ack is the MAX_WAIT-th one.
  assign timeout   = TIMEOUT_EN && (wait_cnt == LAST_CNT);

  // Decoded from the state register only: no input-to-stall path.
  assign stall_out = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lsu_load     <= 1'b0;
      lsu_f3       <= 3'd0;
      lsu_off      <= 2'd0;
      lsu_rd       <= 5'd0;
      lsu_rw       <= 1'b0;
      lsu_addr     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      exc_valid    <= 1'b0;
      exc_cause    <= 4'd0;
      exc_addr     <= '0;
    end else begin
      // Retire indications are single-cycle pulses.
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= 32'(alu_result_in);
              wb_rd        <= rd_in;
              wb_reg_write <= reg_write_in;
            end else if (illegal || misaligned) begin
              // wb_data keeps its previous value; the write is suppressed.
              wb_valid     <= 1'b1;
              wb_rd        <= rd_in;
              wb_reg_write <= 1'b0;
              exc_valid    <= 1'b1;
              exc_cause    <= req_cause;
              exc_addr     <= alu_result_in;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write_en_in;
              dmem_addr  <= {alu_result_in[ADDR_W-1:2], 2'b00};
              dmem_wdata <= lane_wdata;
              dmem_be    <= mem_write_en_in ? lane_be : 4'b0000;
              lsu_load   <= mem_read_en_in;
              lsu_f3     <= funct3_in;
              lsu_off    <= alu_result_in[1:0];
              lsu_rd     <= rd_in;
              lsu_rw     <= reg_write_in;
              lsu_addr   <= alu_result_in;
              wait_cnt   <= '0;
              state      <= BUSY;
            end
          end
        end

        BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (dmem_ack || timeout) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= lsu_rd;
            if (!dmem_ack || dmem_err) begin
              wb_reg_write <= 1'b0;
              exc_valid    <= 1'b1;
              exc_cause    <= lsu_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
              exc_addr     <= lsu_addr;
            end else begin
              wb_reg_write <= lsu_rw;
              // Stores leave wb_data untouched.
              if (lsu_load) begin
                wb_data <= load_data;
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A driver issues
//            directed and random instructions and pushes expected retire
//            records and expected memory requests into queues; a memory
//            responder checks each request and answers with a chosen
//            latency; a monitor pops and compares every retired instruction.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic        mem_read_en_in;
  logic        mem_write_en_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        dmem_err;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] addr;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;     // 0 = never acknowledge
    logic        err;
    logic [31:0] rdata;
  } req_t;

  wb_t  exp_q[$];
  req_t req_q[$];

  int checks = 0;
  int failures = 0;
  bit in_reset_test = 0;
  bit late_ack = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + driver ----------------
  task automatic issue(input bit re, input bit wr, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] sd, input bit [4:0] rd,
                       input bit rw, input int lat, input bit err,
                       input bit [31:0] rdata, input bit track);
    wb_t  e;
    req_t r;
    bit   mem, illegal, mis;
    int   size, off, delay, guard;
    bit [31:0] mask, v;

    mem     = re || wr;
    size    = 1 << f3[1:0];
    off     = int'(a[1:0]);
    illegal = (re && wr) || (re && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 >= 3);
    mis     = mem && !illegal && ((a % size) != 0);

    e.data = 32'd0; e.chk_data = 0; e.rd = rd; e.rw = rw;
    e.exc = 0; e.cause = 4'd0; e.addr = a; e.cyc = 0;
    r.addr = a & 32'hFFFF_FFFC; r.we = wr; r.be = 4'd0; r.wdata = 32'd0;
    r.lat = lat; r.err = err; r.rdata = rdata;
    delay = 0;

    if (!mem) begin
      e.data = a;
      e.chk_data = 1;
    end else if (illegal || mis) begin
      e.exc = 1;
      e.rw = 0;
      e.cause = illegal ? 4'd2 : (re ? 4'd4 : 4'd6);
    end else begin
      delay = (lat != 0) ? lat : MAX_WAIT;
      if (wr) begin
        r.be = 4'(((1 << size) - 1) << off);
        if (size == 1)      r.wdata = sd[7:0] * 32'h0101_0101;
        else if (size == 2) r.wdata = sd[15:0] * 32'h0001_0001;
        else                r.wdata = sd;
      end
      if (err || lat == 0) begin
        e.exc = 1;
        e.rw = 0;
        e.cause = re ? 4'd5 : 4'd7;
      end else if (re) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e.data = v;
        e.chk_data = 1;
      end
    end

    valid_in = 1; alu_result_in = a; store_data_in = sd;
    mem_read_en_in = re; mem_write_en_in = wr; funct3_in = f3;
    rd_in = rd; reg_write_in = rw;

    guard = 0;
    while (stall_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: stall_out stuck at %0b, expected release", stall_out);
    end
    @(negedge clk);   // accepting edge has passed
    e.cyc = cyc + delay;
    if (track) begin
      exp_q.push_back(e);
      if (mem && !illegal && !mis) req_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    valid_in = 0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int   k;
    req_t cur;
    k = 0;
    cur = '{addr: 0, we: 0, be: 0, wdata: 0, lat: 0, err: 0, rdata: 0};
    dmem_ack = 0; dmem_err = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk); #1;
      dmem_ack = 0; dmem_err = 0; dmem_rdata = $urandom;
      if (late_ack) begin
        dmem_ack = 1;
      end else if (in_reset_test || !rst_n) begin
        k = 0;
      end else begin
        chk("stall_vs_req", {31'd0, stall_out}, {31'd0, dmem_req});
        if (dmem_req) begin
          if (k == 0) begin
            if (req_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_req: dmem_req=1 addr 0x%08h, expected no request", dmem_addr);
              cur = '{addr: dmem_addr, we: dmem_we, be: dmem_be, wdata: dmem_wdata,
                      lat: 1, err: 0, rdata: 0};
            end else begin
              cur = req_q.pop_front();
            end
          end
          k++;
          chk("req_addr", dmem_addr, cur.addr);
          chk("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
          chk("req_be", {28'd0, dmem_be}, {28'd0, cur.be});
          if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
          if (cur.lat == k) begin
            dmem_ack = 1;
            dmem_err = cur.err;
            dmem_rdata = cur.rdata;
          end
        end else if (k != 0) begin
          chk("req_cycles", k, (cur.lat != 0) ? cur.lat : MAX_WAIT);
          k = 0;
        end
      end
    end
  end

  // ---------------- retire monitor ----------------
  initial begin
    wb_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb: wb_valid=1 rd=%0d, expected no retire", wb_rd);
        end else begin
          e = exp_q.pop_front();
          chk("wb_cycle", cyc, e.cyc);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
          chk("exc_valid", {31'd0, exc_valid}, {31'd0, e.exc});
          if (e.exc) begin
            chk("exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
            chk("exc_addr", exc_addr, e.addr);
          end
          if (e.chk_data) chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit re, wr;
    bit [2:0] f3;
    bit [31:0] a;
    int lat, kind;
    rst_n = 0; valid_in = 0; alu_result_in = 0; store_data_in = 0;
    mem_read_en_in = 0; mem_write_en_in = 0; funct3_in = 0;
    rd_in = 0; reg_write_in = 0;
    #12;
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle(2);

    // SB 0x1003, ack on first BUSY cycle
    issue(0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd3, 0, 1, 0, 32'd0, 1); idle(3);
    // LB / LBU 0x2002, ack on the fourth BUSY cycle
    issue(1, 0, 3'b000, 32'h2002, 32'd0, 5'd5, 1, 4, 0, 32'h0080_0000, 1); idle(2);
    issue(1, 0, 3'b100, 32'h2002, 32'd0, 5'd6, 1, 4, 0, 32'h0080_0000, 1); idle(2);
    // misaligned LW and SH
    issue(1, 0, 3'b010, 32'h3002, 32'd0, 5'd7, 1, 1, 0, 32'd0, 1); idle(2);
    issue(0, 1, 3'b001, 32'h3001, 32'h1234, 5'd0, 0, 1, 0, 32'd0, 1); idle(2);
    // SW timeout, LW bus error
    issue(0, 1, 3'b010, 32'h4000, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 32'd0, 1); idle(2);
    issue(1, 0, 3'b010, 32'h4004, 32'd0, 5'd8, 1, 2, 1, 32'h1111_1111, 1); idle(2);
    // illegal encoding
    issue(1, 1, 3'b010, 32'h4008, 32'd0, 5'd9, 1, 1, 0, 32'd0, 1); idle(2);
    // ADD then two back-to-back LWs with single-cycle ack
    issue(0, 0, 3'b000, 32'h0000_0055, 32'd0, 5'd10, 1, 0, 0, 32'd0, 1);
    issue(1, 0, 3'b010, 32'h5000, 32'd0, 5'd11, 1, 1, 0, 32'hCAFE_0001, 1);
    issue(1, 0, 3'b010, 32'h5004, 32'd0, 5'd12, 1, 1, 0, 32'hCAFE_0002, 1);
    idle(4);

    // asynchronous reset in the middle of a transaction
    in_reset_test = 1;
    issue(1, 0, 3'b010, 32'h6000, 32'd0, 5'd13, 1, 0, 0, 32'd0, 0);
    idle(1);
    #3 rst_n = 0;
    #1;
    chk("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall_out}, 32'd0);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    late_ack = 1;
    @(negedge clk);
    late_ack = 0;
    repeat (3) begin
      @(negedge clk); #2;
      chk("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    end
    in_reset_test = 0;
    idle(1);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      re = (kind >= 2 && kind <= 5) || (kind == 9 && $urandom_range(0, 1) == 1);
      wr = (kind >= 6 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr)                   f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAX_WAIT);
      issue(re, wr, f3, a, $urandom, 5'($urandom), 1'($urandom), lat,
            ($urandom_range(0, 7) == 0), $urandom, 1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
    end
    idle(MAX_WAIT + 6);

    chk("pending_wb", exp_q.size(), 32'd0);
    chk("pending_req", req_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
